// File: rtl/attractor_sweeper.sv
// attractor_sweeper
// Walks every initial state 0..2^WIDTH-1 through an external combinational
// gene network, finds the attractor reached from each one with Brent's
// algorithm and hands out one classified result per initial state over a
// valid/ready port.
//
// Build option: define ATTRACTOR_TRANSIENT_EN to also measure the transient
// length (steps from the initial state to the first attractor state) into
// o_res_mu. Without it the tail states are not built and o_res_mu reads 0.
//
// Reset: i_rst_n, asynchronous, active low; clears everything including an
// in-flight sweep, which does not resume afterwards.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for i_start (ignored while o_busy is still high)
// S_LOAD     | seed tortoise/hare with the current initial state
// S_RUN      | one network step per cycle, Brent cycle search
// S_TAIL_ADV | (transient) hare walks len steps ahead of init
// S_TAIL_H   | (transient) advance hare one step
// S_TAIL_T   | (transient) advance tortoise one step, count mu, compare
// S_REPORT   | result held on the output until accepted

module attractor_sweeper #(
  parameter int WIDTH     = 8,
  parameter int MAX_STEPS = 1024,
  localparam int LW       = $clog2(MAX_STEPS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_net_state,
  input  logic [WIDTH-1:0] i_net_next,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_init,
  output logic [1:0]       o_res_kind,
  output logic [LW-1:0]    o_res_len,
  output logic [LW-1:0]    o_res_mu,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] KIND_FIXED   = 2'd0;
  localparam logic [1:0] KIND_CYCLE   = 2'd1;
  localparam logic [1:0] KIND_TIMEOUT = 2'd2;
  localparam logic [WIDTH-1:0] INIT_LAST = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_REPORT   = 3'd3
`ifdef ATTRACTOR_TRANSIENT_EN
    ,
    S_TAIL_ADV = 3'd4,
    S_TAIL_H   = 3'd5,
    S_TAIL_T   = 3'd6
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_init;
  logic [WIDTH-1:0] r_tort;
  logic [WIDTH-1:0] r_hare;
  // power and lam carry one extra bit: power can reach 2^LW
  logic [LW:0]      r_power;
  logic [LW:0]      r_lam;
  logic [LW-1:0]    r_steps;
  logic [1:0]       r_kind;
  logic [LW-1:0]    r_len;
  logic             r_busy;
  logic             r_done;
`ifdef ATTRACTOR_TRANSIENT_EN
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    r_mu;
`endif

  logic [LW:0]      w_lam_inc;
  logic [LW-1:0]    w_steps_inc;
  logic [LW-1:0]    w_len;
  logic             w_hit;
  logic             w_budget_out;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;

  assign w_lam_inc    = r_lam + {{LW{1'b0}}, 1'b1};
  assign w_steps_inc  = r_steps + LW'(1);
  // lam' never exceeds the step count, so it always fits in LW bits
  assign w_len        = w_lam_inc[LW-1:0];
  assign w_hit        = (i_net_next == r_tort);
  assign w_budget_out = (w_steps_inc == LW'(MAX_STEPS));
  assign w_start_ok   = (r_state == S_IDLE) && i_start && !r_busy;
  assign w_accept     = (r_state == S_REPORT) && i_res_ready;
  assign w_last       = (r_init == INIT_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_hit) begin
`ifdef ATTRACTOR_TRANSIENT_EN
          w_state_nxt = S_TAIL_ADV;
`else
          w_state_nxt = S_REPORT;
`endif
        end else if (w_budget_out) begin
          w_state_nxt = S_REPORT;
        end
      end
`ifdef ATTRACTOR_TRANSIENT_EN
      S_TAIL_ADV: begin
        // last advance: new hare is on net_next, tortoise still at init
        if (r_cnt == LW'(1)) begin
          if (i_net_next == r_tort) begin
            w_state_nxt = S_REPORT;
          end else begin
            w_state_nxt = S_TAIL_H;
          end
        end
      end
      S_TAIL_H: begin
        w_state_nxt = S_TAIL_T;
      end
      S_TAIL_T: begin
        if (i_net_next == r_hare) begin
          w_state_nxt = S_REPORT;
        end else begin
          w_state_nxt = S_TAIL_H;
        end
      end
`endif
      S_REPORT: begin
        if (i_res_ready) begin
          w_state_nxt = w_last ? S_IDLE : S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs: all taken from registers, so res_valid has no path from res_ready
  always_comb begin
    o_res_valid = (r_state == S_REPORT);
    o_res_init  = r_init;
    o_res_kind  = r_kind;
    o_res_len   = r_len;
    o_busy      = r_busy;
    o_done      = r_done;
`ifdef ATTRACTOR_TRANSIENT_EN
    o_res_mu    = r_mu;
    o_net_state = (r_state == S_TAIL_T) ? r_tort : r_hare;
`else
    o_res_mu    = '0;
    o_net_state = r_hare;
`endif
  end

  // Datapath: Brent search, result capture, sweep bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init  <= '0;
      r_tort  <= '0;
      r_hare  <= '0;
      r_power <= '0;
      r_lam   <= '0;
      r_steps <= '0;
      r_kind  <= KIND_FIXED;
      r_len   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ATTRACTOR_TRANSIENT_EN
      r_cnt   <= '0;
      r_mu    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      // busy drops the cycle after the done pulse
      if (r_done) begin
        r_busy <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_busy <= 1'b1;
            r_init <= '0;
          end
        end
        S_LOAD: begin
          r_tort  <= r_init;
          r_hare  <= r_init;
          r_power <= {{LW{1'b0}}, 1'b1};
          r_lam   <= '0;
          r_steps <= '0;
        end
        S_RUN: begin
          r_steps <= w_steps_inc;
          if (w_hit) begin
            r_len  <= w_len;
            r_kind <= (w_len == LW'(1)) ? KIND_FIXED : KIND_CYCLE;
`ifdef ATTRACTOR_TRANSIENT_EN
            r_hare <= r_init;
            r_tort <= r_init;
            r_cnt  <= w_len;
            r_mu   <= '0;
`endif
          end else if (w_budget_out) begin
            r_kind <= KIND_TIMEOUT;
            r_len  <= '0;
`ifdef ATTRACTOR_TRANSIENT_EN
            r_mu   <= '0;
`endif
          end else begin
            r_hare <= i_net_next;
            if (w_lam_inc == r_power) begin
              r_tort  <= i_net_next;
              r_power <= {r_power[LW-1:0], 1'b0};
              r_lam   <= '0;
            end else begin
              r_lam   <= w_lam_inc;
            end
          end
        end
`ifdef ATTRACTOR_TRANSIENT_EN
        S_TAIL_ADV: begin
          r_hare <= i_net_next;
          r_cnt  <= r_cnt - LW'(1);
        end
        S_TAIL_H: begin
          r_hare <= i_net_next;
        end
        S_TAIL_T: begin
          r_tort <= i_net_next;
          r_mu   <= r_mu + LW'(1);
        end
`endif
        S_REPORT: begin
          if (w_accept) begin
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_init <= r_init + WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_attractor_sweeper.sv
// Testbench for attractor_sweeper: two instances (MAX_STEPS 1024 and 16)
// driven by a switchable network; results checked against a reference that
// walks the orbit as an indexed sequence.
module tb_attractor_sweeper;

  localparam int MS_A = 1024;
  localparam int MS_B = 16;
`ifdef ATTRACTOR_TRANSIENT_EN
  localparam bit TRANS = 1'b1;
`else
  localparam bit TRANS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, b_start = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
  logic [7:0]  a_state, a_next, b_state, b_next, a_init, b_init;
  logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [1:0]  a_kind, b_kind;
  logic [10:0] a_len, a_mu;
  logic [4:0]  b_len, b_mu;

  int         net_mode = 0;
  int         sel = 0;
  logic [7:0] lut [0:255];
  int         rec_kind [0:255];
  int         rec_len  [0:255];
  int         rec_mu   [0:255];
  int         n_checks = 0;
  int         n_pass   = 0;

  logic       m_valid, m_busy, m_done;
  logic [7:0] m_init, m_state;
  logic [1:0] m_kind;
  int         m_len, m_mu;

  attractor_sweeper #(.WIDTH(8), .MAX_STEPS(MS_A)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start),
    .o_net_state(a_state), .i_net_next(a_next),
    .o_res_valid(a_valid), .i_res_ready(a_ready),
    .o_res_init(a_init), .o_res_kind(a_kind), .o_res_len(a_len), .o_res_mu(a_mu),
    .o_busy(a_busy), .o_done(a_done));

  attractor_sweeper #(.WIDTH(8), .MAX_STEPS(MS_B)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start),
    .o_net_state(b_state), .i_net_next(b_next),
    .o_res_valid(b_valid), .i_res_ready(b_ready),
    .o_res_init(b_init), .o_res_kind(b_kind), .o_res_len(b_len), .o_res_mu(b_mu),
    .o_busy(b_busy), .o_done(b_done));

  function automatic logic [7:0] net_f(input logic [7:0] x, input int mode, input logic [7:0] tab);
    case (mode)
      0:       return x;
      1:       return ~x;
      2:       return x + 8'd1;
      3:       return x >> 1;
      default: return tab;
    endcase
  endfunction

  always_comb a_next = net_f(a_state, net_mode, lut[a_state]);
  always_comb b_next = net_f(b_state, net_mode, lut[b_state]);

  always_comb begin
    if (sel != 0) begin
      m_valid = b_valid; m_busy = b_busy; m_done = b_done; m_init = b_init;
      m_state = b_state; m_kind = b_kind; m_len = int'(b_len); m_mu = int'(b_mu);
    end else begin
      m_valid = a_valid; m_busy = a_busy; m_done = a_done; m_init = a_init;
      m_state = a_state; m_kind = a_kind; m_len = int'(a_len); m_mu = int'(a_mu);
    end
  end

  // Reference: x_s compared against x_(p-1), p the largest power of two <= s.
  // lat = cycles from the start/handshake sample to the result sample.
  task automatic model(input logic [7:0] init, input int maxs,
                       output int kind, output int len, output int mu, output int lat);
    int xs [0:1024];
    int steps;
    int p;
    logic [7:0] cur;
    xs[0] = int'(init);
    kind = 2; len = 0; mu = 0; steps = maxs;
    for (int s = 1; s <= maxs; s++) begin
      cur = 8'(xs[s-1]);
      xs[s] = int'(net_f(cur, net_mode, lut[cur]));
      p = 1;
      while (p * 2 <= s) p = p * 2;
      if (xs[s] == xs[p-1]) begin
        len = s - p + 1;
        kind = (len == 1) ? 0 : 1;
        steps = s;
        break;
      end
    end
    if (TRANS && kind != 2) begin
      while (xs[mu] != xs[mu + len]) mu++;
    end
    lat = steps + 2 + ((TRANS && kind != 2) ? (len + 2 * mu) : 0);
  endtask

  task automatic drive_start(input int which, input logic v);
    if (which != 0) b_start = v; else a_start = v;
  endtask

  task automatic drive_ready(input int which, input logic v);
    if (which != 0) b_ready = v; else a_ready = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Starts a sweep and checks the first nres results (all 256 -> done checks too)
  task automatic run_sweep(input int which, input int mode, input int nres,
                           input int bp_init, input bit rnd_ready, input bit poke_start);
    int maxs, expect_init, cnt, done_cnt, hold, guard, got;
    int ekind, elen, emu, elat;
    int s_len, s_mu;
    logic [7:0] s_init;
    logic [1:0] s_kind;
    logic rdy;
    bit seen;
    maxs = (which != 0) ? MS_B : MS_A;
    expect_init = 0; cnt = 0; done_cnt = 0; hold = 0; guard = 0; got = 0; seen = 0;
    s_len = 0; s_mu = 0; s_init = '0; s_kind = '0;
    sel = which;
    net_mode = mode;
    @(negedge clk);
    drive_start(which, 1'b1);
    @(negedge clk);
    drive_start(which, 1'b0);
    cnt = 1;
    n_checks++;
    if (m_busy !== 1'b1) $display("FAIL busy_rise: got %0b expected 1", m_busy);
    else n_pass++;
    while (got < nres) begin
      if (m_valid) begin
        if (!seen) begin
          model(8'(expect_init), maxs, ekind, elen, emu, elat);
          n_checks++;
          if (m_init !== 8'(expect_init)) $display("FAIL res_init: got %0d expected %0d", m_init, expect_init);
          else n_pass++;
          n_checks++;
          if (int'(m_kind) != ekind) $display("FAIL res_kind init=%0d: got %0d expected %0d", expect_init, m_kind, ekind);
          else n_pass++;
          n_checks++;
          if (m_len != elen) $display("FAIL res_len init=%0d: got %0d expected %0d", expect_init, m_len, elen);
          else n_pass++;
          n_checks++;
          if (m_mu != emu) $display("FAIL res_mu init=%0d: got %0d expected %0d", expect_init, m_mu, emu);
          else n_pass++;
          n_checks++;
          if (cnt != elat) $display("FAIL latency init=%0d: got %0d expected %0d", expect_init, cnt, elat);
          else n_pass++;
          n_checks++;
          if (m_busy !== 1'b1) $display("FAIL busy_hold init=%0d: got %0b expected 1", expect_init, m_busy);
          else n_pass++;
          rec_kind[expect_init] = int'(m_kind);
          rec_len[expect_init]  = m_len;
          rec_mu[expect_init]   = m_mu;
          s_init = m_init; s_kind = m_kind; s_len = m_len; s_mu = m_mu;
          seen = 1;
        end else begin
          n_checks++;
          if (m_init !== s_init || m_kind !== s_kind || m_len != s_len || m_mu != s_mu)
            $display("FAIL hold_stable init=%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     expect_init, m_init, m_kind, m_len, m_mu, s_init, s_kind, s_len, s_mu);
          else n_pass++;
        end
        if (expect_init == bp_init && hold < 5) begin
          rdy = 1'b0;
          hold++;
        end else begin
          rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        drive_ready(which, rdy);
        if (rdy) begin
          got++; expect_init++; seen = 0; cnt = 0;
        end
      end else begin
        drive_ready(which, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      if (m_done) done_cnt++;
      drive_start(which, (poke_start && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      @(negedge clk);
      cnt++; guard++;
      if (guard > 60000) begin
        n_checks++;
        $display("FAIL sweep_budget: got %0d results expected %0d", got, nres);
        break;
      end
    end
    drive_start(which, 1'b0);
    drive_ready(which, 1'b0);
    if (nres == 256) begin
      n_checks++;
      if (done_cnt != 0) $display("FAIL early_done: got %0d expected 0", done_cnt);
      else n_pass++;
      n_checks++;
      if (m_done !== 1'b1 || m_busy !== 1'b1) $display("FAIL done_pulse: got done=%0b busy=%0b expected 1/1", m_done, m_busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) $display("FAIL busy_fall: got done=%0b busy=%0b expected 0/0", m_done, m_busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_state !== 8'd0 || a_valid !== 1'b0 || a_init !== 8'd0 || a_kind !== 2'd0)
      $display("FAIL reset_a0: got %0d/%0b/%0d/%0d expected 0/0/0/0", a_state, a_valid, a_init, a_kind);
    else n_pass++;
    n_checks++;
    if (a_len !== 11'd0 || a_mu !== 11'd0 || a_busy !== 1'b0 || a_done !== 1'b0)
      $display("FAIL reset_a1: got %0d/%0d/%0b/%0b expected 0/0/0/0", a_len, a_mu, a_busy, a_done);
    else n_pass++;
    n_checks++;
    if (b_state !== 8'd0 || b_valid !== 1'b0 || b_busy !== 1'b0 || b_len !== 5'd0)
      $display("FAIL reset_b: got %0d/%0b/%0b/%0d expected 0/0/0/0", b_state, b_valid, b_busy, b_len);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0) $display("FAIL idle_no_start: got busy=%0b valid=%0b expected 0/0", a_busy, a_valid);
    else n_pass++;
  endtask

  task automatic test_identity();
    int nfixed;
    run_sweep(0, 0, 256, -1, 1'b0, 1'b0);
    nfixed = 0;
    for (int i = 0; i < 256; i++) if (rec_kind[i] == 0 && rec_len[i] == 1) nfixed++;
    n_checks++;
    if (nfixed != 256) $display("FAIL identity_fixed: got %0d expected 256", nfixed);
    else n_pass++;
  endtask

  task automatic test_complement();
    run_sweep(0, 1, 256, -1, 1'b0, 1'b0);
    n_checks++;
    if (rec_kind[0] != 1 || rec_len[0] != 2) $display("FAIL complement_0: got %0d/%0d expected 1/2", rec_kind[0], rec_len[0]);
    else n_pass++;
  endtask

  task automatic test_increment();
    run_sweep(0, 2, 3, -1, 1'b0, 1'b0);
    n_checks++;
    if (rec_kind[1] != 1 || rec_len[1] != 256) $display("FAIL increment_len: got %0d/%0d expected 1/256", rec_kind[1], rec_len[1]);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_timeout();
    run_sweep(1, 2, 256, -1, 1'b0, 1'b0);
    n_checks++;
    if (rec_kind[200] != 2 || rec_len[200] != 0) $display("FAIL timeout_200: got %0d/%0d expected 2/0", rec_kind[200], rec_len[200]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    run_sweep(0, 0, 8, 3, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic test_shift();
    run_sweep(0, 3, 256, -1, 1'b0, 1'b0);
    n_checks++;
    if (rec_kind[128] != 0 || rec_len[128] != 1 || rec_mu[128] != (TRANS ? 8 : 0))
      $display("FAIL shift_80: got %0d/%0d/%0d expected 0/1/%0d", rec_kind[128], rec_len[128], rec_mu[128], TRANS ? 8 : 0);
    else n_pass++;
    n_checks++;
    if (rec_mu[5] != (TRANS ? 3 : 0)) $display("FAIL shift_05: got %0d expected %0d", rec_mu[5], TRANS ? 3 : 0);
    else n_pass++;
    n_checks++;
    if (rec_mu[0] != 0 || rec_kind[0] != 0) $display("FAIL shift_00: got %0d/%0d expected 0/0", rec_mu[0], rec_kind[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom_range(0, 255));
    run_sweep(0, 4, 256, -1, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom_range(0, 255));
    run_sweep(1, 4, 256, -1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    int bad;
    run_sweep(0, 1, 64, -1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (a_init !== 8'h40 || a_busy !== 1'b1) $display("FAIL midrun_pos: got init=%0d busy=%0b expected 64/1", a_init, a_busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_state !== 8'd0 || a_valid !== 1'b0 || a_init !== 8'd0 || a_kind !== 2'd0 ||
        a_len !== 11'd0 || a_mu !== 11'd0 || a_busy !== 1'b0 || a_done !== 1'b0)
      $display("FAIL midrun_reset: got %0d/%0b/%0d/%0d/%0d/%0d/%0b/%0b expected all 0",
               a_state, a_valid, a_init, a_kind, a_len, a_mu, a_busy, a_done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_state !== 8'd0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL no_resume: got %0d active cycles expected 0", bad);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      lut[i] = 8'd0; rec_kind[i] = -1; rec_len[i] = -1; rec_mu[i] = -1;
    end
    test_reset();
    test_identity();
    test_complement();
    test_increment();
    test_timeout();
    test_backpressure();
    test_shift();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/attractor_sweeper.md
# attractor_sweeper

- Autonomous sweep engine for Boolean gene networks of parameterised width.
- Presents every initial state 0..2^WIDTH-1 in turn to an external combinational network and iterates it.
- Detects the reached attractor with Brent's algorithm and returns one classified result per initial state (fixed point, cycle with length, or timeout) over a valid/ready handshake.
- Sits between a gene-network instance and result logging; replaces bench-driven sweeping and the separate fixed-point/cycle checkers.

## Interface
Parameters:
- WIDTH, 8, network state width (≥1).
- MAX_STEPS, 1024, iteration budget per initial state; LW = $clog2(MAX_STEPS+1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- start  in  1  sampled in IDLE; starts a full sweep.
- net_state  out  WIDTH  registered state presented to the network.
- net_next  in  WIDTH  combinational network output for net_state, same cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result when it is high together with res_valid.
- res_init  out  WIDTH  initial state of this result.
- res_kind  out  2  0 FIXED, 1 CYCLE, 2 TIMEOUT, 3 reserved.
- res_len  out  LW  attractor length (1 for FIXED, 0 for TIMEOUT).
- res_mu  out  LW  transient length (see Configuration).
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final result is accepted.

## Operation
- States: IDLE, LOAD, RUN, [TAIL_ADV, TAIL_H, TAIL_T], REPORT.
- IDLE → LOAD on start=1. Reload init=0.
- LOAD:
  - tort ← init, hare ← init, power ← 1, lam ← 0, steps ← 0.
  - Go to RUN.
- RUN, each cycle:
  - net_state = hare.
  - n = net_next, lam' = lam+1, steps ← steps+1.
  - If n == tort: found, length = lam'.
  - Else if steps+1 == MAX_STEPS: TIMEOUT.
  - Else hare ← n.
    - If lam' == power: tort ← n, power ← power<<1, lam ← 0.
    - Otherwise lam ← lam'.
- On found: res_kind = FIXED if length==1, else CYCLE. Go to REPORT, or to TAIL_ADV when the tail feature is compiled in.
- TIMEOUT goes to REPORT with res_len=0, res_mu=0.
- REPORT:
  - res_valid=1 and fields held stable until handshake.
  - If init == 2^WIDTH-1 on handshake: done pulse, then IDLE.
  - Otherwise init ← init+1, then LOAD.
- power and lam are LW+1 bits wide; power never exceeds 2*MAX_STEPS.
- start while busy is ignored.
- reset low mid-sweep aborts immediately; the sweep does not resume.

## Timing
- Reset values: net_state=0, res_valid=0, res_init=0, res_kind=0, res_len=0, res_mu=0, busy=0, done=0.
- start at cycle t → busy=1 at t+1; first net_state=0 evaluated at t+2.
- Result latency per init: 1 (LOAD) + k RUN cycles [+ tail cycles] + 1; res_valid rises the cycle after detection.
- Fixed-point init: res_valid 3 cycles after LOAD entry.
- res_valid falls the cycle after handshake. No combinational path from res_ready to res_valid.
- With res_ready tied high, back-to-back results are spaced 1 + k + 1 cycles.

## Configuration
- ATTRACTOR_TRANSIENT_EN defined:
  - After detection: TAIL_ADV advances hare from init by len steps (len cycles); tort ← init, mu ← 0.
  - If tort == hare, go to REPORT.
  - Otherwise alternate TAIL_H (hare ← f(hare)) and TAIL_T (tort ← f(tort), mu ← mu+1), comparing after TAIL_T.
  - res_mu = number of steps from init to the first attractor state.
- Not defined: tail states are absent, res_mu is tied to 0, and results issue directly after detection.

## Test plan
- Identity network, WIDTH=8, res_ready=1: 256 results, res_init 0..255 in order, all FIXED len=1; exactly one done pulse; busy falls the cycle after done.
- Complement network (~x): every result CYCLE len=2; init 0x00 result 5 cycles after LOAD entry.
- Increment mod 256, MAX_STEPS=1024: every result CYCLE len=256. With MAX_STEPS=16: every result TIMEOUT len=0.
- Backpressure: hold res_ready=0 for 5 cycles on init 0x03 → res_valid and all fields unchanged, init not advanced; handshake then proceeds to 0x04.
- reset low during RUN of init 0x40 → all outputs at reset values asynchronously; after release, no activity until start.
- ATTRACTOR_TRANSIENT_EN, network x>>1: init 0x80 → FIXED len=1, mu=8; init 0x00 → mu=0; init 0x05 → mu=3.
